// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU: default widths and the program-memory
// controller state encoding.
package cpu_pkg;

  localparam int unsigned INST_W_DEF = 19;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/prog_mem_loader.sv
// RUN/LOAD controller for the program memory: owns the write pointer and the
// saturating count of words written since the last load_start.
module prog_mem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_start,
  input  logic [ADDR_W-1:0] i_load_base,
  input  logic              i_load_valid,
  input  logic              i_load_done,
  output state_e            o_state,
  output logic              o_loading,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr
);

  // Count saturates at the full depth, 2**ADDR_W.
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_d;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_d;
  logic                w_wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    w_wr_en   = 1'b0;
    // load_start restarts from any state and suppresses write and load_done.
    if (i_load_start) begin
      w_state_d = LOAD;
      w_ptr_d   = i_load_base;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        RUN: begin
        end
        LOAD: begin
          if (i_load_valid) begin
            w_wr_en = 1'b1;
            w_ptr_d = r_ptr + 1'b1;
            if (r_cnt != CNT_MAX) begin
              w_cnt_d = r_cnt + 1'b1;
            end
          end
          if (i_load_done) begin
            w_state_d = RUN;
          end
        end
      endcase
    end
  end

  // Memory is not reset, so never write while reset is asserted.
  assign o_wr_en      = w_wr_en & rst_n;
  assign o_wr_addr    = r_ptr;
  assign o_state      = r_state;
  assign o_loading    = (r_state == LOAD);
  assign o_load_count = r_cnt;

endmodule

// File: rtl/prog_mem.sv
// Synchronous-read instruction memory with a valid/stall fetch port and a
// run-time program-load port fed by prog_mem_loader.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] instruction,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_done,
  output logic              loading,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_inst;
  logic              r_valid;

  state_e            w_state;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;

  prog_mem_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (load_start),
    .i_load_base  (load_base),
    .i_load_valid (load_valid),
    .i_load_done  (load_done),
    .o_state      (w_state),
    .o_loading    (loading),
    .o_load_count (load_count),
    .o_wr_en      (w_wr_en),
    .o_wr_addr    (w_wr_addr)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= load_data;
    end
  end

  always_comb begin
    fetch_ready = rst_n && (w_state == RUN) && !stall && !load_start;
  end

  // instruction keeps its last value whenever nothing is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
    end else if (load_start || (w_state == LOAD)) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= fetch_req;
      if (fetch_req) begin
        r_inst <= r_mem[pc];
      end
    end
  end

  assign inst_valid  = r_valid;
  assign instruction = r_inst;

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: directed vector table, a counter-saturation run and
// randomized traffic checked against a behavioural memory model.
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [7:0]  pc;
  logic        stall;
  logic        fetch_ready;
  logic        inst_valid;
  logic [18:0] instruction;
  logic        load_start;
  logic [7:0]  load_base;
  logic        load_valid;
  logic [18:0] load_data;
  logic        load_done;
  logic        loading;
  logic [8:0]  load_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_mem #(
    .INST_W (19),
    .ADDR_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .loading     (loading),
    .load_count  (load_count)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic [7:0]  pc;
    logic        stl;
    logic        ls;
    logic [7:0]  base;
    logic        lv;
    logic [18:0] ld;
    logic        dn;
    logic        rdy;
    logic        val;
    logic [18:0] ins;
    logic        ldg;
    logic [8:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: memory image plus the observable controller state.
  logic [18:0] m_mem [256];
  bit          m_load = 1'b0;
  int          m_ptr  = 0;
  int          m_cnt  = 0;
  bit          m_val  = 1'b0;
  logic [18:0] m_ins  = '0;

  task automatic tv(input int rst, input int req, input int p, input int stl, input int ls,
                    input int b, input int lv, input int d, input int dn, input int rdy,
                    input int val, input int ins, input int ldg, input int cnt);
    vec_t v;
    v.rst = rst[0]; v.req = req[0]; v.pc = 8'(p); v.stl = stl[0]; v.ls = ls[0];
    v.base = 8'(b); v.lv = lv[0]; v.ld = 19'(d); v.dn = dn[0];
    v.rdy = rdy[0]; v.val = val[0]; v.ins = 19'(ins); v.ldg = ldg[0]; v.cnt = 9'(cnt);
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input vec_t v);
    if (!v.rst) begin
      m_load = 1'b0; m_ptr = 0; m_cnt = 0; m_val = 1'b0; m_ins = '0;
    end else begin
      if (v.ls || m_load) m_val = 1'b0;
      else if (!v.stl) begin
        m_val = v.req;
        if (v.req) m_ins = m_mem[v.pc];
      end
      if (v.ls) begin
        m_load = 1'b1; m_ptr = int'(v.base); m_cnt = 0;
      end else if (m_load) begin
        if (v.lv) begin
          m_mem[m_ptr] = v.ld;
          m_ptr = (m_ptr + 1) % 256;
          if (m_cnt < 256) m_cnt++;
        end
        if (v.dn) m_load = 1'b0;
      end
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tab);
    logic e_rdy;
    rst_n = v.rst; fetch_req = v.req; pc = v.pc; stall = v.stl; load_start = v.ls;
    load_base = v.base; load_valid = v.lv; load_data = v.ld; load_done = v.dn;
    @(negedge clk);
    e_rdy = use_tab ? v.rdy : (v.rst && !m_load && !v.stl && !v.ls);
    chk("fetch_ready", 32'(fetch_ready), 32'(e_rdy));
    @(posedge clk);
    model_step(v);
    #1;
    if (use_tab) begin
      chk("tab.inst_valid", 32'(inst_valid), 32'(v.val));
      chk("tab.instruction", 32'(instruction), 32'(v.ins));
      chk("tab.loading", 32'(loading), 32'(v.ldg));
      chk("tab.load_count", 32'(load_count), 32'(v.cnt));
    end else begin
      chk("mdl.inst_valid", 32'(inst_valid), 32'(m_val));
      chk("mdl.instruction", 32'(instruction), 32'(m_ins));
      chk("mdl.loading", 32'(loading), 32'(m_load));
      chk("mdl.load_count", 32'(load_count), 32'(m_cnt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    //  rst req pc    stl ls base   lv data      dn   rdy val ins       ldg cnt
    tv(0, 1, 0,     0, 0, 0,     0, 0,        0,   0, 0, 0,        0, 0);
    tv(0, 1, 0,     0, 0, 0,     0, 0,        0,   0, 0, 0,        0, 0);
    // back-to-back fetch of the zero-initialised image
    tv(1, 1, 0,     0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 0);
    tv(1, 1, 1,     0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 0);
    tv(1, 1, 2,     0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 0);
    tv(1, 1, 3,     0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 0);
    tv(1, 0, 0,     0, 0, 0,     0, 0,        0,   1, 0, 0,        0, 0);
    // load 1..4 at base 0; fetch with load_start refused; last word with load_done
    tv(1, 1, 0,     0, 1, 'h00,  0, 0,        0,   0, 0, 0,        1, 0);
    tv(1, 0, 0,     0, 0, 0,     1, 1,        0,   0, 0, 0,        1, 1);
    tv(1, 0, 0,     0, 0, 0,     1, 2,        0,   0, 0, 0,        1, 2);
    tv(1, 0, 0,     0, 0, 0,     1, 3,        0,   0, 0, 0,        1, 3);
    tv(1, 0, 0,     0, 0, 0,     1, 4,        1,   0, 0, 0,        0, 4);
    tv(1, 1, 0,     0, 0, 0,     0, 0,        0,   1, 1, 1,        0, 4);
    tv(1, 1, 1,     0, 0, 0,     0, 0,        0,   1, 1, 2,        0, 4);
    tv(1, 1, 2,     0, 0, 0,     0, 0,        0,   1, 1, 3,        0, 4);
    tv(1, 1, 3,     0, 0, 0,     0, 0,        0,   1, 1, 4,        0, 4);
    tv(1, 0, 0,     0, 0, 0,     1, 7,        1,   1, 0, 4,        0, 4);
    tv(1, 1, 4,     0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 4);
    // stall holds output for 3 cycles, next fetch accepted when stall drops
    tv(1, 1, 3,     0, 0, 0,     0, 0,        0,   1, 1, 4,        0, 4);
    tv(1, 1, 5,     1, 0, 0,     0, 0,        0,   0, 1, 4,        0, 4);
    tv(1, 1, 5,     1, 0, 0,     0, 0,        0,   0, 1, 4,        0, 4);
    tv(1, 1, 5,     1, 0, 0,     0, 0,        0,   0, 1, 4,        0, 4);
    tv(1, 1, 1,     0, 0, 0,     0, 0,        0,   1, 1, 2,        0, 4);
    tv(1, 0, 0,     0, 0, 0,     0, 0,        0,   1, 0, 2,        0, 4);
    // pointer wrap from 0xFE
    tv(1, 0, 0,     0, 1, 'hFE,  0, 0,        0,   0, 0, 2,        1, 0);
    tv(1, 0, 0,     0, 0, 0,     1, 'h1AAAA,  0,   0, 0, 2,        1, 1);
    tv(1, 0, 0,     0, 0, 0,     1, 'h0BBBB,  0,   0, 0, 2,        1, 2);
    tv(1, 0, 0,     0, 0, 0,     1, 'h7CCCC,  1,   0, 0, 2,        0, 3);
    tv(1, 1, 'hFE,  0, 0, 0,     0, 0,        0,   1, 1, 'h1AAAA,  0, 3);
    tv(1, 1, 'hFF,  0, 0, 0,     0, 0,        0,   1, 1, 'h0BBBB,  0, 3);
    tv(1, 1, 'h00,  0, 0, 0,     0, 0,        0,   1, 1, 'h7CCCC,  0, 3);
    tv(1, 1, 'h01,  0, 0, 0,     0, 0,        0,   1, 1, 2,        0, 3);
    // restart inside LOAD beats load_valid and load_done
    tv(1, 0, 0,     0, 1, 'h20,  0, 0,        0,   0, 0, 2,        1, 0);
    tv(1, 0, 0,     0, 0, 0,     1, 5,        0,   0, 0, 2,        1, 1);
    tv(1, 0, 0,     0, 1, 'h30,  1, 6,        1,   0, 0, 2,        1, 0);
    tv(1, 0, 0,     0, 0, 0,     1, 7,        1,   0, 0, 2,        0, 1);
    tv(1, 1, 'h20,  0, 0, 0,     0, 0,        0,   1, 1, 5,        0, 1);
    tv(1, 1, 'h30,  0, 0, 0,     0, 0,        0,   1, 1, 7,        0, 1);
    tv(1, 1, 'h31,  0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 1);
    // reset after two writes; written words survive
    tv(1, 1, 'h20,  0, 0, 0,     0, 0,        0,   1, 1, 5,        0, 1);
    tv(1, 0, 0,     0, 1, 'h10,  0, 0,        0,   0, 0, 5,        1, 0);
    tv(1, 0, 0,     0, 0, 0,     1, 'h111,    0,   0, 0, 5,        1, 1);
    tv(1, 0, 0,     0, 0, 0,     1, 'h222,    0,   0, 0, 5,        1, 2);
    tv(0, 1, 0,     0, 0, 0,     0, 0,        0,   0, 0, 0,        0, 0);
    tv(1, 1, 'h10,  0, 0, 0,     0, 0,        0,   1, 1, 'h111,    0, 0);
    tv(1, 1, 'h11,  0, 0, 0,     0, 0,        0,   1, 1, 'h222,    0, 0);
    tv(1, 1, 'h12,  0, 0, 0,     0, 0,        0,   1, 1, 0,        0, 0);
    tv(1, 0, 0,     0, 0, 0,     0, 0,        0,   1, 0, 0,        0, 0);

    foreach (vecs[i]) run_cycle(vecs[i], 1'b1);

    // count saturation: 258 writes starting at 0x40
    v = vecs[vecs.size() - 1];
    v.req = 1'b0; v.stl = 1'b0; v.ls = 1'b1; v.base = 8'h40; v.lv = 1'b0; v.dn = 1'b0;
    run_cycle(v, 1'b0);
    v.ls = 1'b0; v.lv = 1'b1;
    for (int i = 0; i < 258; i++) begin
      v.ld = 19'(i * 37 + 3);
      run_cycle(v, 1'b0);
    end
    chk("load_count_sat", 32'(load_count), 32'd256);
    v.lv = 1'b0; v.dn = 1'b1;
    run_cycle(v, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      v.rst  = ($urandom_range(63) != 0);
      v.req  = ($urandom_range(3) != 0);
      v.pc   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
      v.stl  = ($urandom_range(3) == 0);
      v.ls   = ($urandom_range(19) == 0);
      v.base = 8'($urandom_range(15));
      v.lv   = ($urandom_range(1) != 0);
      v.ld   = 19'($urandom);
      v.dn   = ($urandom_range(7) == 0);
      run_cycle(v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, clocked instruction memory for the 19-bit CPU. It replaces the combinational ROM with a synchronous-read array that has a valid/stall fetch handshake and a run-time program-load port with an auto-incrementing write pointer. It sits between the fetch stage (PC in, instruction out) and the test/boot loader that fills it before execution.

## Interface
- INST_W, 19, instruction word width
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- fetch_req  input  1  fetch request for address pc
- pc  input  ADDR_W  fetch address
- stall  input  1  downstream not accepting; hold current output
- fetch_ready  output  1  request accepted this cycle when high with fetch_req
- inst_valid  output  1  instruction holds a fetched word
- instruction  output  INST_W  fetched word
- load_start  input  1  pulse: enter LOAD, pointer := load_base
- load_base  input  ADDR_W  first load address
- load_valid  input  1  load_data is valid this cycle
- load_data  input  INST_W  word to write
- load_done  input  1  pulse: leave LOAD
- loading  output  1  high while in LOAD
- load_count  output  ADDR_W+1  words written since last load_start, saturating

## Operation
- FSM states: RUN, LOAD. Reset -> RUN.
- RUN: fetch_ready = !stall. fetch_req & fetch_ready -> instruction <= mem[pc], inst_valid <= 1. No accepted request and !stall -> inst_valid <= 0; instruction holds its last value.
- stall high: inst_valid and instruction hold; fetch_req ignored.
- RUN + load_start -> LOAD. Same-cycle fetch_req is not accepted (fetch_ready = 0 whenever load_start is high). Pointer := load_base, load_count := 0, inst_valid <= 0.
- LOAD: fetch_ready = 0, inst_valid = 0. load_valid -> mem[ptr] <= load_data, ptr <= ptr + 1 modulo 2**ADDR_W (0xFF wraps to 0x00), load_count increments, saturating at 2**ADDR_W.
- LOAD + load_done -> RUN. load_valid in the same cycle is still written. load_start in LOAD restarts: pointer := load_base, count := 0, no write that cycle.
- load_valid/load_done are ignored in RUN. load_start and load_done in the same cycle: load_start wins.
- Memory contents are not affected by reset. Simulation initial contents are all zero.
- Reset values: fetch_ready 0 during reset, inst_valid 0, instruction 0, loading 0, load_count 0, pointer 0.
- Reset mid-LOAD: returns to RUN. Words already written persist.

## Timing
- Fetch latency: 1 cycle, from accepted request at edge N to inst_valid/instruction at N+1.
- Back-to-back fetches: 1 per cycle while !stall.
- Write-then-read: a word loaded at edge N is readable by a fetch accepted at edge N+2, after load_done at N+1.
- loading rises 1 cycle after load_start and falls 1 cycle after load_done.
- All outputs are registered, except fetch_ready, which is combinational from state, stall and load_start.

## Structure
- Shared package (cpu_pkg): INST_W and ADDR_W defaults, and the state enum {RUN, LOAD}.
- Optional sub-module: prog_mem_loader (FSM, pointer, count), which drives the write enable and address into a plain 1R1W array inside prog_mem.

## Test plan
- Reset, then fetch pc 0..3 back-to-back -> inst_valid high from cycle 2, instructions 0,0,0,0, and fetch_ready high every cycle.
- load_start with base 0x00, write 1,2,3,4 over 4 cycles, load_done, then fetch 0..3 -> 1,2,3,4 and load_count = 4.
- Base 0xFE, load 3 words A,B,C -> mem[0xFE]=A, mem[0xFF]=B, mem[0x00]=C (wrap).
- Fetch pc 5 while stall is held for 3 cycles -> instruction and inst_valid unchanged, fetch_ready low, and the next fetch is accepted on the cycle stall drops.
- fetch_req together with load_start -> not accepted, and inst_valid is 0 during LOAD. load_valid together with load_done -> word written.
- Assert rst_n low mid-LOAD after 2 writes -> all outputs at reset values on the next cycle, state RUN, and the 2 written words are readable.
